// File: rtl/dmem_arbiter_if.sv
// Bus bundle between dmem_arbiter, its two requesters (CPU MEM stage, debug/loader)
// and the single-port data memory; slave = arbiter side, master = environment side.
interface dmem_arbiter_if #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 64,
  parameter int IDX_W  = 5
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [WORD_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [WORD_W-1:0] dbg_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [IDX_W-1:0]  mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/debug arbiter and access sequencer for the single-port data memory.
// Optional macro DMEM_ARB_BOUNDS_EN: address bits above the memory window flag an error.
module dmem_arbiter #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 64,
  parameter int IDX_W  = 5
) (
  input logic           im_clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t r_state, w_state_nxt;

  logic              r_last_dbg, r_owner_dbg, r_we, r_bad;
  logic              r_gnt_cpu, r_gnt_dbg, r_rvalid_cpu, r_rvalid_dbg;
  logic              r_mem_read, r_mem_write, r_err;
  logic [IDX_W-1:0]  r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata, r_rdata_cpu, r_rdata_dbg;

  logic              w_take, w_pick_dbg, w_we, w_bad;
  logic [IDX_W+2:0]  w_addr_lo;
  logic [WORD_W-1:0] w_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    // On a tie the port that did not own the last access wins.
    w_pick_dbg  = bus.dbg_req & ~(bus.cpu_req & r_last_dbg);
    w_we        = w_pick_dbg ? bus.dbg_we    : bus.cpu_we;
    w_wdata     = w_pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
    w_addr_lo   = w_pick_dbg ? bus.dbg_addr[IDX_W+2:0] : bus.cpu_addr[IDX_W+2:0];
`ifdef DMEM_ARB_BOUNDS_EN
    w_bad       = (|w_addr_lo[2:0]) |
                  (w_pick_dbg ? |bus.dbg_addr[ADDR_W-1:IDX_W+3]
                              : |bus.cpu_addr[ADDR_W-1:IDX_W+3]);
`else
    w_bad       = |w_addr_lo[2:0];
`endif
    case (r_state)
      IDLE: begin
        if (bus.cpu_req | bus.dbg_req) begin
          w_take      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = r_we ? IDLE : RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge im_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are loaded on the IDLE->ISSUE edge so they appear registered in ISSUE.
  always_ff @(posedge im_clk) begin
    if (reset) begin
      r_last_dbg   <= 1'b1;
      r_owner_dbg  <= 1'b0;
      r_we         <= 1'b0;
      r_bad        <= 1'b0;
      r_gnt_cpu    <= 1'b0;
      r_gnt_dbg    <= 1'b0;
      r_rvalid_cpu <= 1'b0;
      r_rvalid_dbg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_err        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata_cpu  <= '0;
      r_rdata_dbg  <= '0;
    end else begin
      r_gnt_cpu    <= w_take & ~w_pick_dbg;
      r_gnt_dbg    <= w_take & w_pick_dbg;
      r_err        <= w_take & w_bad;
      r_mem_read   <= w_take & ~w_we & ~w_bad;
      r_mem_write  <= w_take & w_we & ~w_bad;
      r_rvalid_cpu <= (r_state == RESP) & ~r_owner_dbg;
      r_rvalid_dbg <= (r_state == RESP) & r_owner_dbg;
      if (w_take) begin
        r_owner_dbg <= w_pick_dbg;
        r_last_dbg  <= w_pick_dbg;
        r_we        <= w_we;
        r_bad       <= w_bad;
        r_mem_addr  <= w_addr_lo[IDX_W+2:3];
        r_mem_wdata <= w_wdata;
      end
      if (r_state == RESP) begin
        if (r_owner_dbg) r_rdata_dbg <= r_bad ? '0 : bus.mem_rdata;
        else             r_rdata_cpu <= r_bad ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_gnt    = r_gnt_cpu;
  assign bus.cpu_rvalid = r_rvalid_cpu;
  assign bus.cpu_rdata  = r_rdata_cpu;
  assign bus.cpu_stall  = bus.cpu_req & ~(bus.cpu_we ? r_gnt_cpu : r_rvalid_cpu);
  assign bus.dbg_gnt    = r_gnt_dbg;
  assign bus.dbg_rvalid = r_rvalid_dbg;
  assign bus.dbg_rdata  = r_rdata_dbg;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-schedule model plus directed
// literal checks; honours DMEM_ARB_BOUNDS_EN for the out-of-window address case.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  dmem_arbiter_if #(.WORD_W(64), .ADDR_W(64), .IDX_W(5)) bus ();

  dmem_arbiter #(.WORD_W(64), .ADDR_W(64), .IDX_W(5)) dut (
    .im_clk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    return (i == 2) ? 64'hA5 : 64'h1000 + 64'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Synchronous memory: registered read data, poison when no read was issued.
  logic [63:0] mem [32];
  bit          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= bus.mem_read ? mem[bus.mem_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // Model: each accepted request schedules its visible events at fixed cycle offsets.
  logic        s_gc[8], s_gd[8], s_rvc[8], s_rvd[8], s_err[8], s_rd[8], s_wr[8];
  logic [63:0] s_dat[8], s_wdat[8];
  logic [4:0]  s_addr[8];
  logic [63:0] ref_mem[32];

  task automatic clr_slot(input int s);
    s_gc[s] = 0; s_gd[s] = 0; s_rvc[s] = 0; s_rvd[s] = 0; s_err[s] = 0;
    s_rd[s] = 0; s_wr[s] = 0; s_dat[s] = '0; s_wdat[s] = '0; s_addr[s] = '0;
  endtask

  initial begin
    int          cyc, free_at, s, t1, t3;
    logic        last_dbg, pick_dbg, we, bad;
    logic [63:0] addr, wd, e_rdc, e_rdd;
    logic [4:0]  idx;
    cyc = 0; free_at = 0; last_dbg = 1; e_rdc = '0; e_rdd = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 8; i++) clr_slot(i);
    forever begin
      @(negedge clk);
      s = cyc % 8;
      if (s_rvc[s]) e_rdc = s_dat[s];
      if (s_rvd[s]) e_rdd = s_dat[s];
      chk("cpu_gnt",    64'(bus.cpu_gnt),    64'(s_gc[s]));
      chk("dbg_gnt",    64'(bus.dbg_gnt),    64'(s_gd[s]));
      chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(s_rvc[s]));
      chk("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(s_rvd[s]));
      chk("cpu_rdata",  bus.cpu_rdata, e_rdc);
      chk("dbg_rdata",  bus.dbg_rdata, e_rdd);
      chk("err",        64'(bus.err),       64'(s_err[s]));
      chk("mem_read",   64'(bus.mem_read),  64'(s_rd[s]));
      chk("mem_write",  64'(bus.mem_write), 64'(s_wr[s]));
      chk("mem_excl",   64'(bus.mem_read & bus.mem_write), 64'd0);
      if (s_rd[s] || s_wr[s]) chk("mem_addr", 64'(bus.mem_addr), 64'(s_addr[s]));
      if (s_wr[s]) chk("mem_wdata", bus.mem_wdata, s_wdat[s]);
      chk("cpu_stall", 64'(bus.cpu_stall),
          64'(bus.cpu_req & ~(bus.cpu_we ? s_gc[s] : s_rvc[s])));
      clr_slot(s);
      if (rst) begin
        for (int i = 0; i < 8; i++) clr_slot(i);
        e_rdc = '0; e_rdd = '0; free_at = cyc + 1; last_dbg = 1;
      end else if (cyc >= free_at && (bus.cpu_req || bus.dbg_req)) begin
        pick_dbg = bus.dbg_req && !(bus.cpu_req && last_dbg);
        last_dbg = pick_dbg;
        we   = pick_dbg ? bus.dbg_we    : bus.cpu_we;
        addr = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
        wd   = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        bad  = (addr % 8) != 0;
`ifdef DMEM_ARB_BOUNDS_EN
        bad  = bad || (addr >= 64'd256);
`endif
        idx  = 5'((addr % 256) / 8);
        t1 = (cyc + 1) % 8;
        s_gc[t1] = !pick_dbg; s_gd[t1] = pick_dbg; s_err[t1] = bad;
        s_rd[t1] = !we && !bad; s_wr[t1] = we && !bad;
        s_addr[t1] = idx; s_wdat[t1] = wd;
        if (we) begin
          if (!bad) ref_mem[idx] = wd;
          free_at = cyc + 2;
        end else begin
          t3 = (cyc + 3) % 8;
          s_rvc[t3] = !pick_dbg; s_rvd[t3] = pick_dbg;
          s_dat[t3] = bad ? 64'd0 : ref_mem[idx];
          free_at = cyc + 3;
        end
      end
      cyc++;
    end
  end

  task automatic drive(input bit dbg, input bit req, input bit we,
                       input logic [63:0] addr, input logic [63:0] wd);
    if (dbg) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
  endtask

  task automatic access(input bit dbg, input bit we, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd,
                        output logic rv, output logic [4:0] ma, output logic mr,
                        output logic mw, output logic er);
    bit ok = 0;
    @(posedge clk); #1;
    drive(dbg, 1'b1, we, addr, wd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg ? bus.dbg_gnt : bus.cpu_gnt) begin ok = 1; break; end
    end
    chk("gnt_seen", 64'(ok), 64'd1);
    ma = bus.mem_addr; mr = bus.mem_read; mw = bus.mem_write; er = bus.err;
    rd = '0; rv = 0;
    if (we) begin
      @(posedge clk); #1;
      drive(dbg, 1'b0, 1'b0, '0, '0);
    end else begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(dbg, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rv = dbg ? bus.dbg_rvalid : bus.cpu_rvalid;
      rd = dbg ? bus.dbg_rdata  : bus.cpu_rdata;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        rv, mr, mw, er;
    logic [4:0]  ma;
    logic        gc[12], gd[12], rvc[12], rvd[12];
    logic [63:0] rdc[12], rdd[12];

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
    chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 64'd0);

    // CPU load of word 2, cycle-by-cycle
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 64'h10, '0);
    @(negedge clk);
    chk("t1_stall_c0", 64'(bus.cpu_stall), 64'd1);
    @(posedge clk); #1; @(negedge clk);
    chk("t1_gnt_c1", 64'(bus.cpu_gnt), 64'd1);
    chk("t1_read_c1", 64'(bus.mem_read), 64'd1);
    chk("t1_addr_c1", 64'(bus.mem_addr), 64'd2);
    chk("t1_stall_c1", 64'(bus.cpu_stall), 64'd1);
    @(posedge clk); #1; @(negedge clk);
    chk("t1_stall_c2", 64'(bus.cpu_stall), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_rvalid_c3", 64'(bus.cpu_rvalid), 64'd1);
    chk("t1_rdata_c3", bus.cpu_rdata, 64'hA5);

    // Store then load back
    access(1'b0, 1'b1, 64'h18, 64'h1234, rd, rv, ma, mr, mw, er);
    chk("t2_st_write", 64'(mw), 64'd1);
    chk("t2_st_addr", 64'(ma), 64'd3);
    access(1'b0, 1'b0, 64'h18, '0, rd, rv, ma, mr, mw, er);
    chk("t2_ld_rv", 64'(rv), 64'd1);
    chk("t2_ld_data", rd, 64'h1234);

    // Misaligned CPU load
    access(1'b0, 1'b0, 64'h0C, '0, rd, rv, ma, mr, mw, er);
    chk("t4_err", 64'(er), 64'd1);
    chk("t4_read", 64'(mr), 64'd0);
    chk("t4_rv", 64'(rv), 64'd1);
    chk("t4_data", rd, 64'd0);

    // Misaligned debug store is granted but dropped
    access(1'b1, 1'b1, 64'h21, 64'hBAD, rd, rv, ma, mr, mw, er);
    chk("mis_st_err", 64'(er), 64'd1);
    chk("mis_st_write", 64'(mw), 64'd0);
    access(1'b1, 1'b0, 64'h20, '0, rd, rv, ma, mr, mw, er);
    chk("mis_st_kept", rd, 64'h1004);

    // Address above the 256-byte window
    access(1'b0, 1'b0, 64'h108, '0, rd, rv, ma, mr, mw, er);
    chk("bnd_rv", 64'(rv), 64'd1);
`ifdef DMEM_ARB_BOUNDS_EN
    chk("bnd_err", 64'(er), 64'd1);
    chk("bnd_read", 64'(mr), 64'd0);
    chk("bnd_data", rd, 64'd0);
`else
    chk("bnd_err", 64'(er), 64'd0);
    chk("bnd_addr", 64'(ma), 64'd1);
    chk("bnd_data", rd, 64'h1001);
`endif

    // Both ports loading continuously from reset: grants alternate CPU first
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'h20, '0);
    drive(1'b1, 1'b1, 1'b0, 64'h28, '0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      gc[k] = bus.cpu_gnt; gd[k] = bus.dbg_gnt;
      rvc[k] = bus.cpu_rvalid; rvd[k] = bus.dbg_rvalid;
      rdc[k] = bus.cpu_rdata; rdd[k] = bus.dbg_rdata;
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rr_g1_cpu", 64'(gc[1]), 64'd1);
    chk("rr_g1_dbg", 64'(gd[1]), 64'd0);
    chk("rr_g4_dbg", 64'(gd[4]), 64'd1);
    chk("rr_g4_cpu", 64'(gc[4]), 64'd0);
    chk("rr_g7_cpu", 64'(gc[7]), 64'd1);
    chk("rr_g10_dbg", 64'(gd[10]), 64'd1);
    chk("rr_rv3_cpu", 64'(rvc[3]), 64'd1);
    chk("rr_rv3_dbg", 64'(rvd[3]), 64'd0);
    chk("rr_rd3_cpu", rdc[3], 64'h1004);
    chk("rr_rv6_dbg", 64'(rvd[6]), 64'd1);
    chk("rr_rd6_dbg", rdd[6], 64'h1005);
    chk("rr_rd6_cpu", rdc[6], 64'h1004);

    // Reset during the RESP cycle of a debug load
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 64'h30, '0);
    @(posedge clk); #1; @(negedge clk);
    chk("rst_a_gnt", 64'(bus.dbg_gnt), 64'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    chk("rst_a_rdata", bus.dbg_rdata, 64'd0);
    chk("rst_a_cpu_rdata", bus.cpu_rdata, 64'd0);
    chk("rst_a_strobes", 64'({bus.mem_read, bus.mem_write, bus.err}), 64'd0);

    // Debug store whose ISSUE edge coincides with reset still lands
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 64'h38, 64'h5A5A);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_b_gnt", 64'(bus.dbg_gnt), 64'd1);
    chk("rst_b_write", 64'(bus.mem_write), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_b_mem7", mem[7], 64'h5A5A);
    chk("rst_b_write_off", 64'(bus.mem_write), 64'd0);
    access(1'b0, 1'b0, 64'h38, '0, rd, rv, ma, mr, mw, er);
    chk("rst_b_readback", rd, 64'h5A5A);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
